// File: rtl/keypad_pkg.sv
// Shared encodings and helpers for the keypad matrix scanner.
// Event codes on KEY_EVENT, one-hot tracker states, and small elaboration helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } key_event_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_HELD  = 3'b010,
        ST_MULTI = 3'b100
    } tracker_state_e;

    // Widest key map the helpers accept (8 rows x 8 columns).
    localparam int MAX_KEYS = 64;

    function automatic logic popcount_is_one(input logic [MAX_KEYS-1:0] v);
        return (v != '0) && ((v & (v - MAX_KEYS'(1))) == '0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-map debouncer: a scan frame snapshot is accepted as the debounced key map
// once it has repeated unchanged for DEBOUNCE_FRAMES consecutive frame ends.
module keypad_frame_debounce #(
    parameter int KEYS            = 16,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [KEYS-1:0] snapshot,
    input  logic            frame_end,
    output logic [KEYS-1:0] key_map,
    output logic            accept
);

    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [KEYS-1:0] prev_snap;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   cnt_next;

    // A changed snapshot counts as the first frame of a new candidate map.
    always_comb begin
        cnt_next = SW'(1);
        if (snapshot == prev_snap) begin
            if (stable_cnt == SW'(DEBOUNCE_FRAMES)) begin
                cnt_next = stable_cnt;
            end else begin
                cnt_next = stable_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_snap  <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
            accept     <= 1'b0;
        end else begin
            accept <= frame_end;
            if (frame_end) begin
                prev_snap  <= snapshot;
                stable_cnt <= cnt_next;
                if (cnt_next == SW'(DEBOUNCE_FRAMES)) begin
                    key_map <= snapshot;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad front end: drives one row low at a time, debounces the full
// key map per frame and reports PRESS / REPEAT / RELEASE events for a single key.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10,
    parameter int CODE_W          = $clog2(ROWS * COLS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [COLS-1:0]   KEY_COL,
    output logic [ROWS-1:0]   KEY_ROW,
    output logic [CODE_W-1:0] KEY_CODE,
    output logic [1:0]        KEY_EVENT,
    output logic              Value_en,
    output logic              KEY_HELD,
    output logic              MULTI_KEY,
    output logic [2:0]        dbg_state
);

    localparam int KEYS    = ROWS * COLS;
    localparam int RW      = $clog2(ROWS);
    localparam int DW      = $clog2(SCAN_DIV);
    localparam int REP_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
    localparam int CW      = $clog2(REP_MAX + 1);

    // Event handshake: Value_en is a one-cycle valid strobe with no ready/backpressure.
    // KEY_EVENT is meaningful only while Value_en is high; KEY_CODE is valid with it
    // and holds its value afterwards. The consumer must take every strobe.

    logic [COLS-1:0] col_meta;
    logic [COLS-1:0] col_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= KEY_COL;
            col_sync <= col_meta;
        end
    end

    logic            scan_en;
    logic [RW-1:0]   row_idx;
    logic [DW-1:0]   dwell_cnt;
    logic [KEYS-1:0] snapshot;
    logic [KEYS-1:0] snap_next;
    logic            last_dwell;
    logic            frame_end;

    assign last_dwell = scan_en && (dwell_cnt == DW'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (row_idx == RW'(ROWS - 1));

    // The current row's columns are merged in combinationally so the frame-end
    // snapshot already contains the last row sampled on the same edge.
    always_comb begin
        snap_next = snapshot;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx == RW'(r)) begin
                snap_next[r*COLS +: COLS] = ~col_sync;
            end
        end
    end

    // KEY_ROW is a rotating registered pattern so the row pins never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_en   <= 1'b0;
            row_idx   <= '0;
            dwell_cnt <= '0;
            snapshot  <= '0;
            KEY_ROW   <= '1;
        end else begin
            scan_en <= 1'b1;
            if (!scan_en) begin
                KEY_ROW <= ~ROWS'(1);
            end else if (last_dwell) begin
                dwell_cnt <= '0;
                snapshot  <= snap_next;
                KEY_ROW   <= {KEY_ROW[ROWS-2:0], KEY_ROW[ROWS-1]};
                if (row_idx == RW'(ROWS - 1)) begin
                    row_idx <= '0;
                end else begin
                    row_idx <= row_idx + RW'(1);
                end
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    logic [KEYS-1:0] key_map;
    logic            accept;

    keypad_frame_debounce #(
        .KEYS            (KEYS),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .snapshot  (snap_next),
        .frame_end (frame_end),
        .key_map   (key_map),
        .accept    (accept)
    );

    logic              map_one;
    logic [CODE_W-1:0] map_code;
    logic [KEYS-1:0]   held_map;

    assign map_one  = popcount_is_one(MAX_KEYS'(key_map));
    assign held_map = KEYS'(1) << KEY_CODE;

    always_comb begin
        map_code = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (key_map[k]) begin
                map_code = CODE_W'(k);
            end
        end
    end

    tracker_state_e    state;
    tracker_state_e    state_next;
    key_event_e        ev_d;
    logic              en_d;
    logic [CODE_W-1:0] code_d;
    logic              held_d;
    logic              multi_d;
    logic [CW-1:0]     rep_cnt;
    logic [CW-1:0]     rep_d;
    logic [CW-1:0]     rep_inc;
    logic              rep_phase;
    logic              rep_phase_d;

    assign dbg_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            KEY_CODE  <= '0;
            KEY_EVENT <= EV_NONE;
            Value_en  <= 1'b0;
            KEY_HELD  <= 1'b0;
            MULTI_KEY <= 1'b0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            state     <= state_next;
            KEY_CODE  <= code_d;
            KEY_EVENT <= ev_d;
            Value_en  <= en_d;
            KEY_HELD  <= held_d;
            MULTI_KEY <= multi_d;
            rep_cnt   <= rep_d;
            rep_phase <= rep_phase_d;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (map_one) begin
                        state_next = ST_HELD;
                    end else if (key_map != '0) begin
                        state_next = ST_MULTI;
                    end
                end
                ST_HELD: begin
                    if (key_map != held_map) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_MULTI: begin
                    if (key_map == '0) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // rep_phase separates the initial delay from the steady repeat interval;
    // rep_cnt restarts from zero after every REPEAT.
    always_comb begin
        ev_d        = EV_NONE;
        en_d        = 1'b0;
        code_d      = KEY_CODE;
        held_d      = KEY_HELD;
        multi_d     = MULTI_KEY;
        rep_d       = rep_cnt;
        rep_phase_d = rep_phase;
        rep_inc     = (rep_cnt == CW'(REP_MAX)) ? rep_cnt : rep_cnt + CW'(1);
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (map_one) begin
                        code_d      = map_code;
                        held_d      = 1'b1;
                        ev_d        = EV_PRESS;
                        en_d        = 1'b1;
                        rep_d       = '0;
                        rep_phase_d = 1'b0;
                    end else if (key_map != '0) begin
                        multi_d = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (key_map == held_map) begin
                        rep_d = rep_inc;
                        if (REPEAT_DELAY != 0) begin
                            if (!rep_phase && rep_inc == CW'(REPEAT_DELAY)) begin
                                ev_d        = EV_REPEAT;
                                en_d        = 1'b1;
                                rep_d       = '0;
                                rep_phase_d = 1'b1;
                            end else if (rep_phase && rep_inc == CW'(REPEAT_RATE)) begin
                                ev_d  = EV_REPEAT;
                                en_d  = 1'b1;
                                rep_d = '0;
                            end
                        end
                    end else begin
                        ev_d   = EV_RELEASE;
                        en_d   = 1'b1;
                        held_d = 1'b0;
                    end
                end
                ST_MULTI: begin
                    if (key_map == '0) begin
                        multi_d = 1'b0;
                    end
                end
                default: begin
                    held_d  = 1'b0;
                    multi_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a 4x4 instance with auto-repeat, a 4x4
// instance without it, and a 2x3 instance, each behind a behavioural key matrix.
module tb_keypad_matrix_scanner;

    localparam logic [1:0] E_PRESS   = 2'd1;
    localparam logic [1:0] E_REPEAT  = 2'd2;
    localparam logic [1:0] E_RELEASE = 2'd3;
    localparam int FR  = 32;
    localparam int FRS = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [3:0]  col_m, row_m, code_m;
    logic [1:0]  ev_m;
    logic        en_m, held_m, multi_m;
    logic [2:0]  st_m;
    logic [3:0]  col_n, row_n, code_n;
    logic [1:0]  ev_n;
    logic        en_n, held_n, multi_n;
    logic [2:0]  st_n;
    logic [2:0]  col_s, code_s;
    logic [1:0]  row_s, ev_s;
    logic        en_s, held_s, multi_s;
    logic [2:0]  st_s;

    logic [15:0] keys_m;
    logic [5:0]  keys_s;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_qn[$];
    logic [7:0]  exp_qs[$];
    int n_cmp = 0;
    int n_bad = 0;

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_FRAMES(3),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_main (
        .CLK(CLK), .RST(RST), .KEY_COL(col_m), .KEY_ROW(row_m), .KEY_CODE(code_m),
        .KEY_EVENT(ev_m), .Value_en(en_m), .KEY_HELD(held_m), .MULTI_KEY(multi_m),
        .dbg_state(st_m));

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_FRAMES(3),
        .REPEAT_DELAY(0), .REPEAT_RATE(2)) dut_norep (
        .CLK(CLK), .RST(RST), .KEY_COL(col_n), .KEY_ROW(row_n), .KEY_CODE(code_n),
        .KEY_EVENT(ev_n), .Value_en(en_n), .KEY_HELD(held_n), .MULTI_KEY(multi_n),
        .dbg_state(st_n));

    keypad_matrix_scanner #(.ROWS(2), .COLS(3), .SCAN_DIV(8), .DEBOUNCE_FRAMES(3),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_small (
        .CLK(CLK), .RST(RST), .KEY_COL(col_s), .KEY_ROW(row_s), .KEY_CODE(code_s),
        .KEY_EVENT(ev_s), .Value_en(en_s), .KEY_HELD(held_s), .MULTI_KEY(multi_s),
        .dbg_state(st_s));

    // Key matrix: a pressed key shorts its column to its row when that row is low.
    always_comb begin
        col_m = '1;
        col_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_m[r] && keys_m[r*4+c]) col_m[c] = 1'b0;
                if (!row_n[r] && keys_m[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    always_comb begin
        col_s = '1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_s[r] && keys_s[r*3+c]) col_s[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ent(input logic [1:0] ev, input int code);
        logic [31:0] c;
        c = code;
        return {ev, c[5:0]};
    endfunction

    task automatic push_mn(input logic [1:0] ev, input int code);
        exp_q.push_back(ent(ev, code));
        exp_qn.push_back(ent(ev, code));
    endtask

    // which: 0 = main instance, 2 = small instance
    task automatic wait_en(input int which, input int budget, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if ((which == 0 && en_m) || (which == 2 && en_s)) begin
                got = 1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    // Scoreboard: every strobe pops the oldest expected {event, code}.
    always @(negedge CLK) begin
        if (en_m) begin
            if (exp_q.size() == 0) check("ev_main_spurious", {ev_m, 2'b00, code_m}, 0);
            else check("ev_main", {ev_m, 2'b00, code_m}, exp_q.pop_front());
        end
        if (en_n) begin
            if (exp_qn.size() == 0) check("ev_norep_spurious", {ev_n, 2'b00, code_n}, 0);
            else check("ev_norep", {ev_n, 2'b00, code_n}, exp_qn.pop_front());
        end
        if (en_s) begin
            if (exp_qs.size() == 0) check("ev_small_spurious", {ev_s, 3'b000, code_s}, 0);
            else check("ev_small", {ev_s, 3'b000, code_s}, exp_qs.pop_front());
        end
    end

    initial begin
        RST    = 1'b1;
        keys_m = '0;
        keys_s = '0;
        repeat (3) @(negedge CLK);
        check("rst_row", row_m, 4'b1111);
        check("rst_row_small", row_s, 2'b11);
        check("rst_code", code_m, 0);
        check("rst_event", ev_m, 0);
        check("rst_en", en_m, 0);
        check("rst_held", held_m, 0);
        check("rst_multi", multi_m, 0);

        // Row rotation after reset release
        RST = 1'b0;
        @(negedge CLK);
        check("row0", row_m, 4'b1110);
        check("row0_small", row_s, 2'b10);
        repeat (8) @(negedge CLK);
        check("row1", row_m, 4'b1101);
        check("row1_small", row_s, 2'b01);
        repeat (8) @(negedge CLK);
        check("row2", row_m, 4'b1011);
        repeat (8) @(negedge CLK);
        check("row3", row_m, 4'b0111);
        repeat (8) @(negedge CLK);
        check("row_wrap", row_m, 4'b1110);

        // Key 9 held: PRESS, REPEATs at 4,6,8,10,12 frames, then RELEASE
        keys_m[9] = 1'b1;
        push_mn(E_PRESS, 9);
        for (int i = 0; i < 5; i++) exp_q.push_back(ent(E_REPEAT, 9));
        wait_en(0, 6 * FR, "press9_seen");
        check("press9_held", held_m, 1);
        check("press9_code", code_m, 9);
        repeat (4 * FR + 16) @(negedge CLK);
        check("rep_after_delay", exp_q.size(), 4);
        repeat (2 * FR) @(negedge CLK);
        check("rep_after_rate", exp_q.size(), 3);
        repeat (3 * FR + 16) @(negedge CLK);
        keys_m[9] = 1'b0;
        push_mn(E_RELEASE, 9);
        repeat (4 * FR + 4) @(negedge CLK);
        check("release9_main_done", exp_q.size(), 0);
        check("release9_norep_done", exp_qn.size(), 0);
        check("release9_held", held_m, 0);

        // Bouncing column for 6 frames, then stable
        for (int i = 0; i < 6; i++) begin
            keys_m[6] = ~keys_m[6];
            repeat (FR) @(negedge CLK);
        end
        check("bounce_no_event_main", exp_q.size(), 0);
        check("bounce_held", held_m, 0);
        keys_m[6] = 1'b1;
        push_mn(E_PRESS, 6);
        wait_en(0, 6 * FR, "press6_seen");
        check("press6_code", code_m, 6);
        keys_m[6] = 1'b0;
        push_mn(E_RELEASE, 6);
        repeat (6 * FR) @(negedge CLK);
        check("release6_done", exp_q.size() + exp_qn.size(), 0);

        // Two keys together: MULTI, no events; then a clean single key
        keys_m[0] = 1'b1;
        keys_m[5] = 1'b1;
        repeat (6 * FR) @(negedge CLK);
        check("multi_set", multi_m, 1);
        check("multi_set_norep", multi_n, 1);
        check("multi_not_held", held_m, 0);
        keys_m[0] = 1'b0;
        keys_m[5] = 1'b0;
        repeat (6 * FR) @(negedge CLK);
        check("multi_clear", multi_m, 0);
        keys_m[15] = 1'b1;
        push_mn(E_PRESS, 15);
        wait_en(0, 6 * FR, "press15_seen");
        check("press15_code", code_m, 15);
        keys_m[15] = 1'b0;
        push_mn(E_RELEASE, 15);
        repeat (6 * FR) @(negedge CLK);
        check("release15_done", exp_q.size() + exp_qn.size(), 0);

        // Reset while key 3 is held: no RELEASE, fresh PRESS afterwards
        keys_m[3] = 1'b1;
        push_mn(E_PRESS, 3);
        wait_en(0, 6 * FR, "press3_seen");
        repeat (FR) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_row", row_m, 4'b1111);
        check("midrst_code", code_m, 0);
        check("midrst_event", ev_m, 0);
        check("midrst_en", en_m, 0);
        check("midrst_held", held_m, 0);
        check("midrst_held_norep", held_n, 0);
        check("midrst_multi", multi_m, 0);
        @(negedge CLK);
        RST = 1'b0;
        push_mn(E_PRESS, 3);
        wait_en(0, 6 * FR, "press3_again");
        check("press3_code", code_m, 3);
        check("press3_held", held_m, 1);
        keys_m[3] = 1'b0;
        push_mn(E_RELEASE, 3);
        repeat (6 * FR) @(negedge CLK);
        check("release3_done", exp_q.size() + exp_qn.size(), 0);

        // 2x3 instance: row 1 / column 2 is code 5
        keys_s[5] = 1'b1;
        exp_qs.push_back(ent(E_PRESS, 5));
        wait_en(2, 6 * FRS, "press5_small_seen");
        check("press5_small_code", code_s, 5);
        check("press5_small_held", held_s, 1);
        keys_s[5] = 1'b0;
        exp_qs.push_back(ent(E_RELEASE, 5));
        repeat (6 * FRS) @(negedge CLK);
        check("release5_small_done", exp_qs.size(), 0);
        check("release5_small_held", held_s, 0);

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
